add_chunked_seq: RTL

//   Parametrised multi-cycle adder/subtractor for wide operands (default 128 bit).

---
 rtl/add_chunked_seq.sv | 98 +++++++++
 1 files changed

// File: rtl/add_chunked_seq.sv
// Multi-cycle wide adder/subtractor: adds CHUNK bits per clock with a registered
// carry between chunks, behind valid/ready handshakes on both sides.
module add_chunked_seq #(
    parameter int WIDTH = 128,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx;
    logic [CHUNK-1:0] a_chk, b_chk;
    logic [CHUNK:0]   chk_sum;
    logic [31:0]      shamt;
    logic [WIDTH-1:0] chunk_mask, chunk_val;
    logic             accept, last, msb_carry;

    assign accept = in_valid && in_ready;
    assign last   = (idx == LAST);

    // Latched operands shift right each RUN cycle, so the live chunk is always at bit 0.
    assign a_chk   = a_q[CHUNK-1:0];
    assign b_chk   = b_q[CHUNK-1:0];
    assign chk_sum = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, carry_q};

    assign shamt      = 32'(idx) * 32'(CHUNK);
    assign chunk_mask = WIDTH'({CHUNK{1'b1}}) << shamt;
    assign chunk_val  = WIDTH'(chk_sum[CHUNK-1:0]) << shamt;

    // Carry into the MSB recovered from the MSB's sum bit and its two operand bits.
    assign msb_carry = chk_sum[CHUNK-1] ^ a_chk[CHUNK-1] ^ b_chk[CHUNK-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= cin;
            idx     <= '0;
        end else if (state == RUN) begin
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            carry_q <= chk_sum[CHUNK];
            idx     <= idx + 1'b1;
            sum     <= (sum & ~chunk_mask) | chunk_val;
            if (last) begin
                cout <= chk_sum[CHUNK];
                ovf  <= chk_sum[CHUNK] ^ msb_carry;
            end
        end
    end
endmodule
